if_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and runs a req/ready handshake with a variable-latency instruction memory. It delivers {pc, instruction} together with a load strobe to IF/ID and generates the IF/ID flush on taken branches. It absorbs hazard-unit stalls by buffering one instruction and drains in-flight memory responses after a redirect.

---
 rtl/if_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC, imem handshake, IF/ID load/flush
//
// Owns the PC, runs a req/ready handshake with a variable-latency instruction
// memory and hands {pc, instruction} to the IF/ID register with a load strobe.
// One instruction is buffered while the hazard unit stalls; memory responses
// that are still in flight after a redirect are drained and dropped.
//
// Optional macro FETCH_PERF_EN builds the two performance counters; without it
// the perf ports are tied to 0.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   stall                 IF/ID must not load this cycle
//   branch_taken          single-cycle redirect pulse from EX
//   branch_target         redirect PC (low 2 bits ignored)
//   imem_req / imem_addr  request and fetch address to instruction memory
//   imem_ready/imem_rdata response strobe and data from instruction memory
//   pc_out/instruction_out delivered {pc, word} to IF/ID
//   if_id_load / if_flush IF/ID load and flush strobes
//   fetch_valid           deliverable instruction present (live or buffered)
//   perf_fetch_count      cycles with if_id_load=1
//   perf_stall_count      cycles with fetch_valid=1 and stall=1

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out,
   output logic        if_id_load,
   output logic        if_flush,
   output logic        fetch_valid,
   output logic [31:0] perf_fetch_count,
   output logic [31:0] perf_stall_count
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] HOLD  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] buf_pc;
   logic [31:0] buf_instr;

   logic in_fetch;
   logic in_hold;
   logic in_drain;

   assign in_fetch = (state == FETCH);
   assign in_hold  = (state == HOLD);
   assign in_drain = (state == DRAIN);

   // Outputs are gated with reset so the reset cycle itself is quiet even
   // though the registers only clear at the end of it.
   assign imem_req    = !reset && in_fetch;
   assign imem_addr   = pc;
   assign fetch_valid = !reset && ((in_fetch && imem_ready) || in_hold);
   assign if_id_load  = fetch_valid && !stall && !branch_taken;
   assign if_flush    = !reset && branch_taken;

   always_comb begin
      pc_out          = 32'd0;
      instruction_out = 32'd0;
      if (fetch_valid) begin
         if (in_hold) begin
            pc_out          = buf_pc;
            instruction_out = buf_instr;
         end else begin
            pc_out          = pc;
            instruction_out = imem_rdata;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         buf_pc    <= 32'd0;
         buf_instr <= 32'd0;
      end else if (branch_taken) begin
         pc        <= branch_target & ~32'h3;
         buf_pc    <= 32'd0;
         buf_instr <= 32'd0;
         // An access is still owed to us if we were mid-request, or already
         // draining and the old response has not arrived yet.
         if ((in_fetch || in_drain) && !imem_ready)
            state <= DRAIN;
         else
            state <= FETCH;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ready && !stall) begin
                  pc <= pc + PC_STEP;
               end else if (imem_ready) begin
                  buf_pc    <= pc;
                  buf_instr <= imem_rdata;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (!stall) begin
                  pc    <= pc + PC_STEP;
                  state <= FETCH;
               end
            end
            DRAIN: begin
               if (imem_ready)
                  state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_count <= 32'd0;
         stall_count <= 32'd0;
      end else begin
         if (if_id_load)
            fetch_count <= fetch_count + 32'd1;
         if (fetch_valid && stall)
            stall_count <= stall_count + 32'd1;
      end
   end

   assign perf_fetch_count = fetch_count;
   assign perf_stall_count = stall_count;
`else
   assign perf_fetch_count = 32'd0;
   assign perf_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit

module tb_if_fetch_unit;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instruction_out;
   logic        if_id_load;
   logic        if_flush;
   logic        fetch_valid;
   logic [31:0] perf_fetch_count;
   logic [31:0] perf_stall_count;

   int assertions = 0;
   int failures   = 0;

   if_fetch_unit dut (
      .clock(clock), .reset(reset), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .pc_out(pc_out), .instruction_out(instruction_out),
      .if_id_load(if_id_load), .if_flush(if_flush), .fetch_valid(fetch_valid),
      .perf_fetch_count(perf_fetch_count), .perf_stall_count(perf_stall_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hC0DE_0001;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic rdy, input logic [31:0] addr, input logic stl,
                        input logic br, input logic [31:0] tgt);
      imem_ready    = rdy;
      imem_rdata    = word(addr);
      stall         = stl;
      branch_taken  = br;
      branch_target = tgt;
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0);
      assertions++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req: got %0b want 0", imem_req); end
      assertions++; if (if_id_load !== 1'b0) begin failures++; $display("FAIL reset_load: got %0b want 0", if_id_load); end
      assertions++; if (if_flush !== 1'b0) begin failures++; $display("FAIL reset_flush: got %0b want 0", if_flush); end
      assertions++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", fetch_valid); end
      assertions++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
      assertions++; if (instruction_out !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", instruction_out); end
      tick();
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
      assertions++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL reset_first_req: got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr); end
      assertions++; if (perf_fetch_count !== 32'd0 || perf_stall_count !== 32'd0) begin failures++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetch_count, perf_stall_count); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'(i * 4);
         drive(1'b1, exp_pc, 1'b0, 1'b0, 32'd0);
         assertions++;
         if (if_id_load !== 1'b1 || pc_out !== exp_pc || instruction_out !== word(exp_pc) || imem_addr !== exp_pc) begin
            failures++;
            $display("FAIL seq_%0d: got load=%0b pc=%h instr=%h addr=%h want load=1 pc=%h instr=%h", i, if_id_load, pc_out, instruction_out, imem_addr, exp_pc, word(exp_pc));
         end
         tick();
      end
   endtask

   task automatic test_stall_hold();
      do_reset();
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0); tick();
      drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0); tick();
      drive(1'b1, 32'h8, 1'b1, 1'b0, 32'd0);
      assertions++; if (fetch_valid !== 1'b1 || if_id_load !== 1'b0 || pc_out !== 32'h8) begin failures++; $display("FAIL stall_capture: got valid=%0b load=%0b pc=%h want 1/0/8", fetch_valid, if_id_load, pc_out); end
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 32'hDEAD, 1'b1, 1'b0, 32'd0);
         assertions++;
         if (imem_req !== 1'b0 || if_id_load !== 1'b0 || fetch_valid !== 1'b1 || pc_out !== 32'h8 || instruction_out !== word(32'h8)) begin
            failures++;
            $display("FAIL stall_hold_%0d: got req=%0b load=%0b valid=%0b pc=%h instr=%h want 0/0/1/8/%h", i, imem_req, if_id_load, fetch_valid, pc_out, instruction_out, word(32'h8));
         end
         tick();
      end
      drive(1'b0, 32'hDEAD, 1'b0, 1'b0, 32'd0);
      assertions++; if (if_id_load !== 1'b1 || pc_out !== 32'h8 || instruction_out !== word(32'h8)) begin failures++; $display("FAIL stall_release: got load=%0b pc=%h instr=%h want 1/8/%h", if_id_load, pc_out, instruction_out, word(32'h8)); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
      assertions++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || fetch_valid !== 1'b0) begin failures++; $display("FAIL stall_next_fetch: got req=%0b addr=%h valid=%0b want 1/c/0", imem_req, imem_addr, fetch_valid); end
   endtask

   task automatic test_branch_hold();
      do_reset();
      drive(1'b1, 32'h0, 1'b1, 1'b0, 32'd0); tick();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h103);
      assertions++; if (if_flush !== 1'b1 || if_id_load !== 1'b0) begin failures++; $display("FAIL br_hold_flush: got flush=%0b load=%0b want 1/0", if_flush, if_id_load); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
      assertions++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_valid !== 1'b0 || if_flush !== 1'b0) begin failures++; $display("FAIL br_hold_target: got req=%0b addr=%h valid=%0b flush=%0b want 1/100/0/0", imem_req, imem_addr, fetch_valid, if_flush); end
      tick();
      drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
      assertions++; if (if_id_load !== 1'b1 || pc_out !== 32'h100 || instruction_out !== word(32'h100)) begin failures++; $display("FAIL br_hold_deliver: got load=%0b pc=%h instr=%h want 1/100/%h", if_id_load, pc_out, instruction_out, word(32'h100)); end
      tick();
   endtask

   task automatic test_drain();
      do_reset();
      drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h20);
      assertions++; if (if_flush !== 1'b1 || if_id_load !== 1'b0) begin failures++; $display("FAIL drain_redirect0: got flush=%0b load=%0b want 1/0", if_flush, if_id_load); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
      assertions++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || if_flush !== 1'b1) begin failures++; $display("FAIL drain_enter: got req=%0b addr=%h flush=%0b want 1/20/1", imem_req, imem_addr, if_flush); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
      assertions++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL drain_wait: got req=%0b valid=%0b want 0/0", imem_req, fetch_valid); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
      assertions++; if (if_flush !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL drain_second_branch: got flush=%0b req=%0b want 1/0", if_flush, imem_req); end
      tick();
      drive(1'b1, 32'h20, 1'b0, 1'b0, 32'd0);
      assertions++; if (if_id_load !== 1'b0 || fetch_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL drain_drop: got load=%0b valid=%0b req=%0b want 0/0/0", if_id_load, fetch_valid, imem_req); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
      assertions++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL drain_refetch: got req=%0b addr=%h want 1/80", imem_req, imem_addr); end
   endtask

   task automatic test_wrap();
      do_reset();
      drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF); tick();
      drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
      assertions++; if (if_id_load !== 1'b1 || pc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_deliver: got load=%0b pc=%h want 1/fffffffc", if_id_load, pc_out); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
      assertions++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_next: got addr=%h req=%0b want 0/1", imem_addr, imem_req); end
   endtask

   task automatic test_perf();
      logic [31:0] exp_f;
      logic [31:0] exp_s;
`ifdef FETCH_PERF_EN
      exp_f = 32'd5; exp_s = 32'd2;
`else
      exp_f = 32'd0; exp_s = 32'd0;
`endif
      do_reset();
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0); tick();
      drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0); tick();
      drive(1'b1, 32'h8, 1'b1, 1'b0, 32'd0); tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'd0); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0); tick();
      drive(1'b1, 32'hC, 1'b0, 1'b0, 32'd0); tick();
      drive(1'b1, 32'h10, 1'b0, 1'b0, 32'd0); tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'd0);
      assertions++; if (perf_fetch_count !== exp_f) begin failures++; $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_count, exp_f); end
      assertions++; if (perf_stall_count !== exp_s) begin failures++; $display("FAIL perf_stall: got %0d want %0d", perf_stall_count, exp_s); end
      do_reset();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
      assertions++; if (perf_fetch_count !== 32'd0 || perf_stall_count !== 32'd0) begin failures++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_fetch_count, perf_stall_count); end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
      imem_ready = 1'b0; imem_rdata = 32'd0;
      test_reset();
      test_sequential();
      test_stall_hold();
      test_branch_hold();
      test_drain();
      test_wrap();
      test_perf();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
